// File: rtl/t00_ssmux_pkg.sv
// t00_ssmux_pkg: shared constants for the seven-segment scan driver.
//   GLYPH      - hex 0..F to segment pattern, bit0 = a ... bit6 = g
//   SEG_A..G   - bit positions of the segments within seg
//   SEG_DP     - bit position of the decimal point within seg
//   MAX_DIGITS - largest supported digit count
package t00_ssmux_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/t00_ssglyph.sv
// t00_ssglyph: combinational hex nibble to seven-segment lookup.
// Ports:
//   nib   in  4  hex digit
//   glyph out 7  segment pattern, laid out by the SEG_A..SEG_G indices
import t00_ssmux_pkg::*;

module t00_ssglyph (
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  logic [6:0] pat;

  // Table entries are stored a..g in bits 0..6; route each bit to its segment index.
  always_comb begin
    pat          = GLYPH[nib];
    glyph        = '0;
    glyph[SEG_A] = pat[0];
    glyph[SEG_B] = pat[1];
    glyph[SEG_C] = pat[2];
    glyph[SEG_D] = pat[3];
    glyph[SEG_E] = pat[4];
    glyph[SEG_F] = pat[5];
    glyph[SEG_G] = pat[6];
  end

endmodule

// File: rtl/t00_ssmux.sv
// t00_ssmux: time-multiplexed seven-segment display driver.
// Scans NDIGITS digits, PRESCALE clocks per digit slot. Value updates go into a
// shadow register and are committed to the displayed value only at the end of a
// frame, so a frame never mixes old and new digits.
// Build option: define T00_SSMUX_LZB_EN for leading-zero blanking (digits above
// the most significant non-zero nibble show no segments; dp and dig unaffected).
// Ports:
//   clk     in   1          system clock
//   nrst    in   1          asynchronous active-low reset
//   value   in   4*NDIGITS  hex value, nibble i -> digit i
//   dp      in   NDIGITS    decimal point per digit (live, not buffered)
//   load    in   1          strobe capturing value
//   enable  in   1          low blanks seg and dig; scanning continues
//   seg     out  8          segments a..g in bits 0..6, dp in bit 7
//   dig     out  NDIGITS    one-hot digit select
//   pending out  1          shadow holds an uncommitted value
//   frame   out  1          one-cycle pulse after each completed frame
import t00_ssmux_pkg::*;

module t00_ssmux #(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [4*NDIGITS-1:0] value,
  input  logic [NDIGITS-1:0]   dp,
  input  logic                 load,
  input  logic                 enable,
  output logic [7:0]           seg,
  output logic [NDIGITS-1:0]   dig,
  output logic                 pending,
  output logic                 frame
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  if (NDIGITS < 1 || NDIGITS > MAX_DIGITS || PRESCALE < 2) begin : g_bad_cfg
    $error("t00_ssmux: unsupported NDIGITS/PRESCALE");
  end

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d;
  logic                   pending_q, pending_d;
  logic [7:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     dig_q, dig_d;
  logic                   frame_q;

  logic                   wrap;
  logic                   boundary;
  logic [3:0]             sel_nib;
  logic                   sel_dp;
  logic [NDIGITS-1:0]     onehot;
  logic [6:0]             glyph;
  logic                   blank;

  t00_ssglyph u_glyph (
    .nib   (sel_nib),
    .glyph (glyph)
  );

  // Prescaler and scan index.
  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (idx_q == IDX_LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffering: a load on the boundary goes straight to disp and wins
  // over any pending shadow value.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (boundary) begin
      if (load) begin
        disp_d    = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // Select the nibble, decimal point and digit strobe of the current slot.
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    onehot  = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib   = disp_q[4*i +: 4];
        sel_dp    = dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef T00_SSMUX_LZB_EN
  // Blank when this digit and every more significant digit are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (IW'(i) >= idx_q && disp_q[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    blank = upper_zero && (idx_q != '0);
  end
`else
  assign blank = 1'b0;
`endif

  // Output next-state; dig stays dark on cnt==0 so adjacent digits never overlap.
  always_comb begin
    seg_d = '0;
    if (enable) begin
      seg_d[SEG_DP]      = sel_dp;
      seg_d[SEG_G:SEG_A] = blank ? 7'h00 : glyph;
    end
    dig_d = (enable && cnt_q != '0) ? onehot : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      dig_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      frame_q   <= boundary;
    end
  end

  assign seg     = seg_q;
  assign dig     = dig_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_t00_ssmux.sv
// tb_t00_ssmux: self-checking bench for t00_ssmux with NDIGITS=4, PRESCALE=4.
// A time-based reference model (slot = t/PRESCALE, frame end every 16 cycles)
// is compared against the DUT every cycle; directed literals pin the model.
module tb_t00_ssmux;

  localparam int ND = 4;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        pending;
  logic        frame;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  t00_ssmux #(
    .NDIGITS  (ND),
    .PRESCALE (PS)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .value   (value),
    .dp      (dp),
    .load    (load),
    .enable  (enable),
    .seg     (seg),
    .dig     (dig),
    .pending (pending),
    .frame   (frame)
  );

  logic [6:0] glyphs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: t counts cycles since reset release.
  int          t;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_pend, e_frame;

  always @(posedge clk) begin
    int         cnt, idx;
    logic       bnd;
    logic [6:0] g;
    if (!nrst) begin
      t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
      e_seg = '0; e_dig = '0; e_pend = 1'b0; e_frame = 1'b0;
    end else begin
      cnt = t % PS;
      idx = (t / PS) % ND;
      bnd = (t % (PS * ND)) == (PS * ND - 1);
      g = glyphs[4'(m_disp >> (4 * idx))];
`ifdef T00_SSMUX_LZB_EN
      if (idx > 0 && (m_disp >> (4 * idx)) == 0) g = 7'h00;
`endif
      e_seg   = enable ? {dp[idx], g} : 8'h00;
      e_dig   = (enable && cnt != 0) ? 4'(1 << idx) : 4'h0;
      e_frame = bnd;
      if (bnd) begin
        if (load) begin
          m_disp = value; m_pend = 1'b0;
        end else if (m_pend) begin
          m_disp = m_shadow; m_pend = 1'b0;
        end
      end else if (load) begin
        m_shadow = value; m_pend = 1'b1;
      end
      e_pend = m_pend;
      t++;
    end
    #1;
    check("model_seg", seg, e_seg);
    check("model_dig", dig, e_dig);
    check("model_pending", pending, e_pend);
    check("model_frame", frame, e_frame);
  end

  // Monitors.
  logic prev_pend = 1'b0;
  int   pend_falls = 0;
  bit   watch5 = 1'b0;
  bit   seen5 = 1'b0;
  always @(negedge clk) begin
    if (prev_pend && !pending) pend_falls++;
    prev_pend = pending;
    if (watch5 && dig != 4'h0 && seg[6:0] == 7'h6D) seen5 = 1'b1;
  end

  // Waits for the next frame pulse; returns cycles waited and lit cycles of digit 0.
  task automatic wait_frame(output int n, output int lit0);
    n = 0; lit0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (dig == 4'b0001) lit0++;
      if (frame) break;
    end
    if (!frame) begin
      tests++; fails++;
      $display("FAIL frame_timeout: no frame pulse within 100 cycles");
    end
  endtask

  task automatic expect_digit(string name, logic [3:0] d, logic [7:0] s);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dig == d) break;
    end
    check({name, "_dig"}, dig, d);
    check(name, seg, s);
  endtask

  task automatic pulse_load(logic [15:0] v);
    value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lit0, frames;
    enable = 1'b1;
    #12;
    check("reset_seg", seg, 8'h00);
    check("reset_dig", dig, 4'h0);
    check("reset_pending", pending, 1'b0);
    check("reset_frame", frame, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("dead_dig", dig, 4'h0);
    check("dead_seg", seg, 8'h3F);
    @(negedge clk);
    check("first_lit_dig", dig, 4'b0001);
    check("first_lit_seg", seg, 8'h3F);

    // Basic load and scan.
    pulse_load(16'h1234);
    check("pend_after_load", pending, 1'b1);
    wait_frame(n, lit0);
    check("pend_after_commit", pending, 1'b0);
    expect_digit("d0_1234", 4'b0001, 8'h66);
    expect_digit("d1_1234", 4'b0010, 8'h4F);
    expect_digit("d2_1234", 4'b0100, 8'h5B);
    expect_digit("d3_1234", 4'b1000, 8'h06);
    wait_frame(n, lit0);
    wait_frame(n, lit0);
    check("frame_period", n, 16);
    check("lit_cycles", lit0, 3);

    // Mid-frame load: old value finishes the frame.
    repeat (5) @(negedge clk);
    pulse_load(16'hABCD);
    check("pend_abcd", pending, 1'b1);
    expect_digit("d3_old", 4'b1000, 8'h06);
    wait_frame(n, lit0);
    check("pend_abcd_commit", pending, 1'b0);
    expect_digit("d0_abcd", 4'b0001, 8'h5E);
    expect_digit("d1_abcd", 4'b0010, 8'h39);
    expect_digit("d2_abcd", 4'b0100, 8'h7C);
    expect_digit("d3_abcd", 4'b1000, 8'h77);

    // Two loads in one frame: last one wins, single commit.
    wait_frame(n, lit0);
    repeat (2) @(negedge clk);
    pend_falls = 0;
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222);
    wait_frame(n, lit0);
    expect_digit("d0_2222", 4'b0001, 8'h5B);
    expect_digit("d1_2222", 4'b0010, 8'h5B);
    expect_digit("d2_2222", 4'b0100, 8'h5B);
    expect_digit("d3_2222", 4'b1000, 8'h5B);
    wait_frame(n, lit0);
    check("pend_falls_once", pend_falls, 1);

    // Load on the boundary cycle overrides pending 5555.
    wait_frame(n, lit0);
    repeat (3) @(negedge clk);
    watch5 = 1'b1;
    pulse_load(16'h5555);
    check("pend_5555", pending, 1'b1);
    repeat (11) @(negedge clk);
    pulse_load(16'h9876);
    check("pend_boundary_load", pending, 1'b0);
    check("frame_boundary_load", frame, 1'b1);
    expect_digit("d0_9876", 4'b0001, 8'h7D);
    expect_digit("d1_9876", 4'b0010, 8'h07);
    expect_digit("d2_9876", 4'b0100, 8'h7F);
    expect_digit("d3_9876", 4'b1000, 8'h67);
    watch5 = 1'b0;
    check("never_shown_5555", seen5, 1'b0);

    // Disable: outputs dark, scanning and frames continue.
    @(negedge clk);
    enable = 1'b0;
    frames = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("dis_seg", seg, 8'h00);
      check("dis_dig", dig, 4'h0);
      if (frame) frames++;
    end
    check("dis_frame_seen", frames > 0, 1'b1);
    enable = 1'b1;
    expect_digit("reenable_d0", 4'b0001, 8'h7D);

    // Leading zeros with a decimal point on digit 2.
    dp = 4'b0100;
    pulse_load(16'h0007);
    wait_frame(n, lit0);
    expect_digit("lz_d0", 4'b0001, 8'h07);
`ifdef T00_SSMUX_LZB_EN
    expect_digit("lz_d1", 4'b0010, 8'h00);
    expect_digit("lz_d2", 4'b0100, 8'h80);
    expect_digit("lz_d3", 4'b1000, 8'h00);
`else
    expect_digit("lz_d1", 4'b0010, 8'h3F);
    expect_digit("lz_d2", 4'b0100, 8'hBF);
    expect_digit("lz_d3", 4'b1000, 8'h3F);
`endif

    // Asynchronous reset mid-frame clears everything including pending.
    repeat (2) @(negedge clk);
    pulse_load(16'h4321);
    check("pend_before_rst", pending, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("arst_seg", seg, 8'h00);
    check("arst_dig", dig, 4'h0);
    check("arst_pending", pending, 1'b0);
    check("arst_frame", frame, 1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst2_dead_dig", dig, 4'h0);
    check("rst2_dead_seg", seg, 8'h3F);
    @(negedge clk);
    check("rst2_d0_dig", dig, 4'b0001);
    check("rst2_d0_seg", seg, 8'h3F);
    check("rst2_pending", pending, 1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
